// File: rtl/mac_stop_ctrl.sv
// Sequencer for the mac_stop_mult datapath: one C = A*B job per start, row-major result writes.
// Optional busy-cycle counter enabled by defining MAC_STOP_CTRL_PERF_EN.
module mac_stop_ctrl #(
  parameter int M                        = 2,
  parameter int K                        = 2,
  parameter int N                        = 2,
  parameter int DATA_WIDTH_INIT_MATRIX   = 32,
  parameter int DATA_WIDTH_RESULT_MATRIX = 2*DATA_WIDTH_INIT_MATRIX+$clog2(K)
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                start,
  input  logic                                stop,
  output logic                                busy,
  output logic                                done,
  output logic                                aborted,
  output logic                                seq_err,
  output logic                                do_mac,
  input  logic                                mult_done_reg,
  input  logic [2*DATA_WIDTH_INIT_MATRIX-1:0] product_reg,
  input  logic                                mac_done,
  output logic                                res_we,
  output logic [$clog2(M)-1:0]                res_row_addr,
  output logic [$clog2(N)-1:0]                res_col_addr,
  output logic [DATA_WIDTH_RESULT_MATRIX-1:0] res_data,
  output logic [31:0]                         cycle_count
);

  localparam int RW = DATA_WIDTH_RESULT_MATRIX;
  localparam int RA = $clog2(M);
  localparam int CA = $clog2(N);
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  localparam logic [RA-1:0] I_LAST = RA'(M-1);
  localparam logic [CA-1:0] J_LAST = CA'(N-1);
  localparam logic [KW-1:0] K_LAST = KW'(K-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [RA-1:0]   i_q;
  logic [CA-1:0]   j_q;
  logic [KW-1:0]   k_q;
  logic [RW-1:0]   acc_q;
  logic [RW-1:0]   acc_sum;
  logic            last_k, last_elem, abort, accept;
  logic            aborted_q, seq_err_q;
  logic [RA-1:0]   row_q;
  logic [CA-1:0]   col_q;
  logic [RW-1:0]   data_q;

  assign acc_sum   = acc_q + RW'(product_reg);
  assign last_k    = (k_q == K_LAST);
  assign last_elem = (i_q == I_LAST) && (j_q == J_LAST);
  assign abort     = stop && (state_q != S_IDLE);
  assign accept    = start && !stop && (state_q == S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (mult_done_reg) state_d = last_k ? S_WRITE : S_ISSUE;
      S_WRITE: state_d = last_elem ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // stop gates the strobes in the same cycle so an abort never leaks a pulse
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign do_mac       = (state_q == S_ISSUE) && !stop;
  assign res_we       = (state_q == S_WRITE) && !stop;
  assign aborted      = aborted_q;
  assign seq_err      = seq_err_q;
  assign res_row_addr = row_q;
  assign res_col_addr = col_q;
  assign res_data     = data_q;

  // result output registers are loaded on the last product so they are valid throughout WRITE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      acc_q  <= '0;
      row_q  <= '0;
      col_q  <= '0;
      data_q <= '0;
    end else if (abort) begin
      acc_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
          end
        end
        S_WAIT: begin
          if (mult_done_reg) begin
            acc_q <= acc_sum;
            if (last_k) begin
              data_q <= acc_sum;
              row_q  <= i_q;
              col_q  <= j_q;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        S_WRITE: begin
          k_q   <= '0;
          acc_q <= '0;
          if (!last_elem) begin
            if (j_q == J_LAST) begin
              j_q <= '0;
              i_q <= i_q + 1'b1;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // seq_err: datapath must flag mac_done exactly on the final element's write
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aborted_q <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      aborted_q <= abort;
      if (accept) seq_err_q <= 1'b0;
      else if (state_q == S_WRITE && !stop && (mac_done != last_elem)) seq_err_q <= 1'b1;
    end
  end

`ifdef MAC_STOP_CTRL_PERF_EN
  logic [31:0] cycle_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     cycle_q <= '0;
    else if (accept) cycle_q <= '0;
    else if (busy)   cycle_q <= cycle_q + 32'd1;
  end

  assign cycle_count = cycle_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_mac_stop_ctrl.sv
// Bench for mac_stop_ctrl: behavioural datapath and matrix-product reference, directed and random jobs.
module tb_mac_stop_ctrl;

  localparam int M  = 2;
  localparam int K  = 2;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int RW = 2*DW+$clog2(K);
  localparam int RA = $clog2(M);
  localparam int CA = $clog2(N);
  localparam int EW = RA+CA+RW;
  localparam int DONE_CYC = M*N*(2*K+1)+1;
`ifdef MAC_STOP_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic            busy, done, aborted, seq_err, do_mac, res_we;
  logic            mult_done_reg, mac_done;
  logic [2*DW-1:0] product_reg;
  logic [RA-1:0]   res_row_addr;
  logic [CA-1:0]   res_col_addr;
  logic [RW-1:0]   res_data;
  logic [31:0]     cycle_count;

  logic [DW-1:0]   a_m [M][K];
  logic [DW-1:0]   b_m [K][N];
  logic [EW-1:0]   exp_q [$];
  logic            force_md0 = 1'b0;
  logic            dp_clr = 1'b0;
  int              issued;
  int              n_chk = 0;
  int              n_pass = 0;

  always #5 clk = ~clk;

  mac_stop_ctrl #(.M(M), .K(K), .N(N), .DATA_WIDTH_INIT_MATRIX(DW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop),
    .busy(busy), .done(done), .aborted(aborted), .seq_err(seq_err),
    .do_mac(do_mac), .mult_done_reg(mult_done_reg), .product_reg(product_reg),
    .mac_done(mac_done), .res_we(res_we), .res_row_addr(res_row_addr),
    .res_col_addr(res_col_addr), .res_data(res_data), .cycle_count(cycle_count)
  );

  // Datapath model: product p of the job is A[i][k]*B[k][j] with k fastest, then j, then i.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mult_done_reg <= 1'b0;
      product_reg   <= '0;
      issued        <= 0;
    end else begin
      mult_done_reg <= do_mac;
      if (dp_clr) begin
        issued <= 0;
      end else if (do_mac) begin
        if (issued < M*N*K)
          product_reg <= (2*DW)'(a_m[issued/(N*K)][issued%K]) *
                         (2*DW)'(b_m[issued%K][(issued/K)%N]);
        issued <= issued + 1;
      end
    end
  end

  assign mac_done = (issued == M*N*K) && !force_md0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_exp();
    logic [RW-1:0] s;
    exp_q.delete();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int k = 0; k < K; k++) s = s + RW'(a_m[i][k]) * RW'(b_m[k][j]);
        exp_q.push_back({RA'(i), CA'(j), s});
      end
  endtask

  task automatic rand_mats();
    for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) a_m[i][k] = $urandom();
    for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) b_m[k][j] = $urandom();
  endtask

  // One job from a negedge: optional stop/restart/reset in a given cycle (0 = never).
  task automatic run_job(input string tag, input int stop_c, input int restart_c, input int rst_c,
                         input bit force_md, input int exp_wr, input int exp_done, input int exp_ab);
    int c = 1;
    int nwr = 0, ndone = 0, nab = 0, nlate = 0;
    logic [EW-1:0] e;
    bit finished = 1'b0;
    start = 1'b1; dp_clr = 1'b1;
    @(negedge clk);
    start = 1'b0; dp_clr = 1'b0;
    chk({tag, "_seq_err_clr"}, seq_err, 1'b0);
    while (c < 60 && !finished) begin
      if (res_we) begin
        nwr++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        chk({tag, "_write"}, {res_row_addr, res_col_addr, res_data}, e);
      end
      if (done) begin
        ndone++;
        chk({tag, "_done_cyc"}, c, DONE_CYC);
        if (force_md) chk({tag, "_seq_err_at_done"}, seq_err, 1'b1);
      end
      if (aborted) nab++;
      if (stop_c > 0 && c > stop_c && (do_mac || res_we)) nlate++;
      if (!busy) begin
        finished = 1'b1;
        if (stop_c > 0) chk({tag, "_idle_cyc"}, c, stop_c+1);
        else if (rst_c == 0) chk({tag, "_idle_cyc"}, c, DONE_CYC+1);
      end else begin
        stop      = (c == stop_c);
        start     = (c == restart_c);
        force_md0 = force_md && (c == DONE_CYC-1);
        if (c == rst_c) begin
          #2 resetn = 1'b0;
          #1 chk({tag, "_async_rst"}, {busy, done, aborted, seq_err, do_mac, res_we,
                 res_row_addr, res_col_addr, res_data, cycle_count}, '0);
          exp_q.delete();
          #1 resetn = 1'b1;
        end
        @(negedge clk);
        c++;
      end
    end
    stop = 1'b0; start = 1'b0; force_md0 = 1'b0;
    if (!finished) chk({tag, "_timeout"}, c, 0);
    chk({tag, "_n_writes"}, nwr, exp_wr);
    chk({tag, "_n_done"}, ndone, exp_done);
    chk({tag, "_n_aborted"}, nab, exp_ab);
    chk({tag, "_late_strobes"}, nlate, 0);
    chk({tag, "_seq_err_end"}, seq_err, force_md);
    if (rst_c > 0) chk({tag, "_cycle_count"}, cycle_count, 0);
    else if (stop_c > 0) chk({tag, "_cycle_count"}, cycle_count, PERF ? stop_c : 0);
    else chk({tag, "_cycle_count"}, cycle_count, PERF ? DONE_CYC : 0);
    if (exp_done > 0) chk({tag, "_exp_left"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    chk({tag, "_cycle_count_hold"}, cycle_count,
        (rst_c > 0 || !PERF) ? 0 : (stop_c > 0 ? stop_c : DONE_CYC));
  endtask

  task automatic set_t1();
    a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = 4;
    b_m[0][0] = 5; b_m[0][1] = 6; b_m[1][0] = 7; b_m[1][1] = 8;
  endtask

  initial begin
    set_t1();
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, aborted, seq_err, do_mac, res_we,
        res_row_addr, res_col_addr, res_data, cycle_count}, '0);
    resetn = 1'b1;
    @(negedge clk);

    // directed 2x2x2 job with literal results
    exp_q.delete();
    exp_q.push_back({1'b0, 1'b0, 65'd19});
    exp_q.push_back({1'b0, 1'b1, 65'd22});
    exp_q.push_back({1'b1, 1'b0, 65'd43});
    exp_q.push_back({1'b1, 1'b1, 65'd50});
    run_job("t1", 0, 0, 0, 1'b0, 4, 1, 0);

    // all-ones operands: full-width sum must not truncate
    for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) a_m[i][k] = '1;
    for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) b_m[k][j] = '1;
    exp_q.delete();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) exp_q.push_back({RA'(i), CA'(j), 65'h1_FFFF_FFFC_0000_0002});
    run_job("ones", 0, 0, 0, 1'b0, 4, 1, 0);

    // abort in the WAIT of element (0,1)
    rand_mats(); load_exp();
    run_job("stop", 2*K+1+2, 0, 0, 1'b0, 1, 0, 1);
    apply_reset();

    // start while busy is ignored
    rand_mats(); load_exp();
    run_job("restart", 0, 5, 0, 1'b0, 4, 1, 0);

    // mac_done withheld on the final write raises seq_err
    rand_mats(); load_exp();
    run_job("seqerr", 0, 0, 0, 1'b1, 4, 1, 0);
    rand_mats(); load_exp();
    run_job("after_seqerr", 0, 0, 0, 1'b0, 4, 1, 0);

    // start+stop together and stop alone in IDLE
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("idle_start_stop_busy", busy, 1'b0);
    chk("idle_start_stop_aborted", aborted, 1'b0);
    @(negedge clk);
    stop = 1'b0;
    chk("idle_stop_aborted", aborted, 1'b0);

    // asynchronous reset mid-job, then a fresh job reproduces the directed case
    rand_mats(); load_exp();
    run_job("midrst", 0, 0, 10, 1'b0, 2, 0, 0);
    set_t1(); load_exp();
    run_job("t1_again", 0, 0, 0, 1'b0, 4, 1, 0);

    for (int r = 0; r < 4; r++) begin
      rand_mats(); load_exp();
      run_job("rand", 0, 0, 0, 1'b0, 4, 1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
